// File: rtl/cpu_test_sequencer_if.sv
// Bundle of every signal between the test sequencer and its environment
// (stimulus streams, IMEM write port, core control, debug read port, status).
// The sequencer uses the master modport and the environment uses the slave modport.
interface cpu_test_sequencer_if #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int TIMEOUT_W  = 16
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic                 start;
  logic                 prog_valid;
  logic                 prog_ready;
  logic [XLEN-1:0]      prog_data;
  logic                 prog_last;
  logic                 chk_valid;
  logic                 chk_ready;
  logic [4:0]           chk_reg;
  logic [XLEN-1:0]      chk_data;
  logic                 chk_last;
  logic                 imem_we;
  logic [AW-1:0]        imem_addr;
  logic [XLEN-1:0]      imem_wdata;
  logic                 cpu_rst;
  logic [XLEN-1:0]      if_insn;
  logic [4:0]           rf_raddr;
  logic [XLEN-1:0]      rf_rdata;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic                 overflow;
  logic [4:0]           fail_reg;
  logic [XLEN-1:0]      fail_data;
  logic [TIMEOUT_W-1:0] run_cycles;

  modport master (
    input  start, prog_valid, prog_data, prog_last,
           chk_valid, chk_reg, chk_data, chk_last, if_insn, rf_rdata,
    output prog_ready, chk_ready, imem_we, imem_addr, imem_wdata, cpu_rst,
           rf_raddr, busy, done, pass, timeout, overflow,
           fail_reg, fail_data, run_cycles
  );

  modport slave (
    output start, prog_valid, prog_data, prog_last,
           chk_valid, chk_reg, chk_data, chk_last, if_insn, rf_rdata,
    input  prog_ready, chk_ready, imem_we, imem_addr, imem_wdata, cpu_rst,
           rf_raddr, busy, done, pass, timeout, overflow,
           fail_reg, fail_data, run_cycles
  );
endinterface

// File: rtl/cpu_test_sequencer.sv
// Self-checking harness that loads a program into IMEM, stores a table of
// expected register values, runs the core until it fetches the halt
// instruction, lets the pipeline drain and then compares the register file
// through the debug read port. Reports pass, fail or timeout.
// Optional feature: define SEQ_CLEAR_IMEM_EN to fill the unused IMEM tail with
// nops after the program is loaded; otherwise stale IMEM contents remain.
module cpu_test_sequencer #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter int              NCHECK     = 8,
  parameter int              TIMEOUT_W  = 16,
  parameter int              DRAIN      = 6,
  parameter logic [XLEN-1:0] HALT_INSN  = 32'h0000_0073
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_test_sequencer_if.master bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(IMEM_DEPTH + 1);
  localparam int IW = $clog2(NCHECK);
  localparam int CW = $clog2(NCHECK + 1);
  localparam int DW = $clog2(DRAIN + 1);
  localparam logic [TIMEOUT_W-1:0] RUN_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, LOAD_PROG, CLEAR, LOAD_CHK, RUN, DRAIN_S, CHECK, DONE
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        idx_q;
  logic [DW-1:0]        drainCnt_q;
  logic                 progReady_q, chkReady_q, imemWe_q, cpuRst_q;
  logic [AW-1:0]        imemAddr_q;
  logic [XLEN-1:0]      imemWdata_q;
  logic [4:0]           rfRaddr_q;
  logic                 busy_q, done_q, pass_q, timeout_q, overflow_q;
  logic [4:0]           failReg_q;
  logic [XLEN-1:0]      failData_q;
  logic [TIMEOUT_W-1:0] runCycles_q;

  logic [4:0]      chkRegMem  [NCHECK];
  logic [XLEN-1:0] chkDataMem [NCHECK];

  logic          progAccept_d, chkAccept_d, progRoom_d, chkRoom_d;
  logic [PW-1:0] ptrNext_d;
  logic [IW-1:0] idxLo_d;
  logic          mismatch_d, lastEntry_d;

  assign progAccept_d = bus.prog_valid && progReady_q;
  assign chkAccept_d  = bus.chk_valid && chkReady_q;
  assign progRoom_d   = ptr_q < PW'(IMEM_DEPTH);
  assign chkRoom_d    = cnt_q < CW'(NCHECK);
  assign ptrNext_d    = progRoom_d ? ptr_q + PW'(1) : ptr_q;
  assign idxLo_d      = idx_q[IW-1:0];
  assign mismatch_d   = bus.rf_rdata != chkDataMem[idxLo_d];
  assign lastEntry_d  = idx_q == cnt_q - CW'(1);

  assign bus.prog_ready = progReady_q;
  assign bus.chk_ready  = chkReady_q;
  assign bus.imem_we    = imemWe_q;
  assign bus.imem_addr  = imemAddr_q;
  assign bus.imem_wdata = imemWdata_q;
  assign bus.cpu_rst    = cpuRst_q;
  assign bus.rf_raddr   = rfRaddr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.overflow   = overflow_q;
  assign bus.fail_reg   = failReg_q;
  assign bus.fail_data  = failData_q;
  assign bus.run_cycles = runCycles_q;

  // Expected-value table: store accepted entries while there is room
  always_ff @(posedge clk) begin
    if (rst && state_q == LOAD_CHK && chkAccept_d && chkRoom_d) begin
      chkRegMem[cnt_q[IW-1:0]]  <= bus.chk_reg;
      chkDataMem[cnt_q[IW-1:0]] <= bus.chk_data;
    end
  end

  // Test sequence FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      drainCnt_q  <= '0;
      progReady_q <= 1'b0;
      chkReady_q  <= 1'b0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuRst_q    <= 1'b1;
      rfRaddr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      failReg_q   <= '0;
      failData_q  <= '0;
      runCycles_q <= '0;
    end else begin
      imemWe_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= LOAD_PROG;
            ptr_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            runCycles_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            failReg_q   <= '0;
            failData_q  <= '0;
            rfRaddr_q   <= '0;
            progReady_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD_PROG: begin
          if (progAccept_d) begin
            ptr_q <= ptrNext_d;
            if (progRoom_d) begin
              imemWe_q    <= 1'b1;
              imemAddr_q  <= ptr_q[AW-1:0];
              imemWdata_q <= bus.prog_data;
            end else begin
              overflow_q <= 1'b1;
            end
            if (bus.prog_last) begin
              progReady_q <= 1'b0;
`ifdef SEQ_CLEAR_IMEM_EN
              if (ptrNext_d < PW'(IMEM_DEPTH)) begin
                state_q <= CLEAR;
              end else begin
                state_q    <= LOAD_CHK;
                chkReady_q <= 1'b1;
              end
`else
              state_q    <= LOAD_CHK;
              chkReady_q <= 1'b1;
`endif
            end
          end
        end
        CLEAR: begin
`ifdef SEQ_CLEAR_IMEM_EN
          imemWe_q    <= 1'b1;
          imemAddr_q  <= ptr_q[AW-1:0];
          imemWdata_q <= XLEN'(32'h0000_0013);
          ptr_q       <= ptr_q + PW'(1);
          if (ptr_q == PW'(IMEM_DEPTH - 1)) begin
            state_q    <= LOAD_CHK;
            chkReady_q <= 1'b1;
          end
`else
          state_q    <= LOAD_CHK;
          chkReady_q <= 1'b1;
`endif
        end
        LOAD_CHK: begin
          if (chkAccept_d) begin
            if (chkRoom_d) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              overflow_q <= 1'b1;
            end
            if (bus.chk_last) begin
              chkReady_q <= 1'b0;
              cpuRst_q   <= 1'b0;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          if (runCycles_q != '1) begin
            runCycles_q <= runCycles_q + TIMEOUT_W'(1);
          end
          if (bus.if_insn == HALT_INSN) begin
            state_q    <= DRAIN_S;
            drainCnt_q <= '0;
          end else if (runCycles_q == RUN_LAST) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            cpuRst_q  <= 1'b1;
          end
        end
        DRAIN_S: begin
          if (drainCnt_q == DW'(DRAIN - 1)) begin
            state_q   <= CHECK;
            cpuRst_q  <= 1'b1;
            idx_q     <= '0;
            rfRaddr_q <= chkRegMem[0];
          end else begin
            drainCnt_q <= drainCnt_q + DW'(1);
          end
        end
        CHECK: begin
          if (mismatch_d) begin
            state_q    <= DONE;
            failReg_q  <= chkRegMem[idxLo_d];
            failData_q <= bus.rf_rdata;
            pass_q     <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else if (lastEntry_d) begin
            state_q <= DONE;
            pass_q  <= !overflow_q && !timeout_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q     <= idx_q + CW'(1);
            rfRaddr_q <= chkRegMem[idxLo_d + IW'(1)];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer: a default instance driven by a tiny
// fetch/register-file model, a short-timeout instance and a small-IMEM instance.
module tb_cpu_test_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_test_sequencer_if #(.XLEN(32), .IMEM_DEPTH(64), .TIMEOUT_W(16)) bus0 ();
  cpu_test_sequencer_if #(.XLEN(32), .IMEM_DEPTH(64), .TIMEOUT_W(8))  bus1 ();
  cpu_test_sequencer_if #(.XLEN(32), .IMEM_DEPTH(4),  .TIMEOUT_W(16)) bus2 ();

  cpu_test_sequencer #(.XLEN(32), .IMEM_DEPTH(64), .NCHECK(8), .TIMEOUT_W(16), .DRAIN(6))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  cpu_test_sequencer #(.XLEN(32), .IMEM_DEPTH(64), .NCHECK(8), .TIMEOUT_W(8), .DRAIN(6))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  cpu_test_sequencer #(.XLEN(32), .IMEM_DEPTH(4), .NCHECK(8), .TIMEOUT_W(16), .DRAIN(6))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  // Instance 0 environment: IMEM image, fetch pointer and register file
  logic [31:0] imem0 [0:63];
  logic [5:0]  pc0;
  logic [31:0] rf0 [0:31];
  int cyc = 0, highWr0 = 0, low0 = 0, wr7Cyc = 0, wr63Cyc = 0;
  assign bus0.if_insn  = imem0[pc0];
  assign bus0.rf_rdata = rf0[bus0.rf_raddr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pc0 <= bus0.cpu_rst ? 6'd0 : pc0 + 6'd1;
    if (bus0.cpu_rst === 1'b0) low0 <= low0 + 1;
    if (bus0.imem_we === 1'b1) begin
      imem0[bus0.imem_addr] <= bus0.imem_wdata;
      if (bus0.imem_addr >= 6'd7) highWr0 <= highWr0 + 1;
      if (bus0.imem_addr == 6'd7) wr7Cyc <= cyc;
      if (bus0.imem_addr == 6'd63) wr63Cyc <= cyc;
    end
  end

  // Instance 1 never halts; instance 2 halts immediately and reads back 5
  assign bus1.if_insn  = 32'h0;
  assign bus1.rf_rdata = 32'h0;
  assign bus2.if_insn  = 32'h0000_0073;
  assign bus2.rf_rdata = 32'd5;

  logic [31:0] imem2 [0:3];
  int writes2 = 0;
  always @(posedge clk) begin
    if (bus2.imem_we === 1'b1) begin
      imem2[bus2.imem_addr] <= bus2.imem_wdata;
      writes2 <= writes2 + 1;
    end
  end

  logic [31:0] prog [0:7];
  logic [4:0]  chkRegs [0:9];
  logic [31:0] chkVals [0:9];

  task automatic startPulse0();
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
  endtask

  task automatic loadProg0(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bus0.prog_valid = 1'b1; bus0.prog_data = prog[i]; bus0.prog_last = (i == n - 1);
      while (bus0.prog_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      total++;
      if (bus0.prog_ready !== 1'b1) begin bad++; $display("[TB] FAIL prog_ready got=%b want=1", bus0.prog_ready); end
      @(negedge clk);
      total++;
      if (bus0.imem_we !== 1'b1 || bus0.imem_addr !== 6'(i) || bus0.imem_wdata !== prog[i]) begin
        bad++;
        $display("[TB] FAIL imem_write[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, bus0.imem_we, bus0.imem_addr, bus0.imem_wdata, i, prog[i]);
      end
    end
    bus0.prog_valid = 1'b0; bus0.prog_last = 1'b0;
  endtask

  task automatic loadChk0(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bus0.chk_valid = 1'b1; bus0.chk_reg = chkRegs[i]; bus0.chk_data = chkVals[i];
      bus0.chk_last = (i == n - 1);
      while (bus0.chk_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      total++;
      if (bus0.chk_ready !== 1'b1) begin bad++; $display("[TB] FAIL chk_ready got=%b want=1", bus0.chk_ready); end
      @(negedge clk);
    end
    bus0.chk_valid = 1'b0; bus0.chk_last = 1'b0;
  endtask

  task automatic waitDone0(input int budget);
    int g = 0;
    while (bus0.done !== 1'b1 && g < budget) begin @(negedge clk); g++; end
    total++;
    if (bus0.done !== 1'b1) begin bad++; $display("[TB] FAIL done_wait got=%b want=1", bus0.done); end
  endtask

  task automatic setGoodTable();
    chkRegs[0] = 5'd1; chkVals[0] = 32'd5;
    chkRegs[1] = 5'd2; chkVals[1] = 32'd10;
    chkRegs[2] = 5'd3; chkVals[2] = 32'd15;
    chkRegs[3] = 5'd4; chkVals[3] = 32'd15;
    chkRegs[4] = 5'd5; chkVals[4] = 32'd20;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus0.cpu_rst !== 1'b1 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.pass !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got cpu_rst=%b busy=%b done=%b pass=%b want 1,0,0,0",
                      bus0.cpu_rst, bus0.busy, bus0.done, bus0.pass);
    end
    total++;
    if (bus0.prog_ready !== 1'b0 || bus0.chk_ready !== 1'b0 || bus0.imem_we !== 1'b0 ||
        bus0.run_cycles !== 16'd0 || bus0.fail_reg !== 5'd0 || bus0.rf_raddr !== 5'd0) begin
      bad++; $display("[TB] FAIL reset_data got pr=%b cr=%b we=%b rc=%0d fr=%0d ra=%0d want all 0",
                      bus0.prog_ready, bus0.chk_ready, bus0.imem_we, bus0.run_cycles, bus0.fail_reg, bus0.rf_raddr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    int low;
    setGoodTable();
    low = low0;
    startPulse0();
    total++;
    if (bus0.busy !== 1'b1 || bus0.prog_ready !== 1'b1 || bus0.cpu_rst !== 1'b1) begin
      bad++; $display("[TB] FAIL load_state got busy=%b ready=%b cpu_rst=%b want 1,1,1",
                      bus0.busy, bus0.prog_ready, bus0.cpu_rst);
    end
    loadProg0(7);
    loadChk0(5);
    waitDone0(300);
    total++;
    if (bus0.pass !== 1'b1 || bus0.fail_reg !== 5'd0 || bus0.timeout !== 1'b0 || bus0.overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL pass_result got pass=%b fail_reg=%0d to=%b ov=%b want 1,0,0,0",
                      bus0.pass, bus0.fail_reg, bus0.timeout, bus0.overflow);
    end
    total++;
    if (bus0.run_cycles !== 16'd7) begin bad++; $display("[TB] FAIL run_cycles got=%0d want=7", bus0.run_cycles); end
    total++;
    if (low0 - low !== 13) begin bad++; $display("[TB] FAIL core_run_len got=%0d want=13", low0 - low); end
    total++;
    if (bus0.busy !== 1'b0 || bus0.cpu_rst !== 1'b1) begin
      bad++; $display("[TB] FAIL done_ctrl got busy=%b cpu_rst=%b want 0,1", bus0.busy, bus0.cpu_rst);
    end
  endtask

  task automatic test_fail_last();
    setGoodTable();
    chkVals[4] = 32'd21;
    startPulse0(); loadProg0(7); loadChk0(5); waitDone0(300);
    total++;
    if (bus0.pass !== 1'b0 || bus0.fail_reg !== 5'd5 || bus0.fail_data !== 32'd20) begin
      bad++; $display("[TB] FAIL fail_last got pass=%b reg=%0d data=%0d want 0,5,20",
                      bus0.pass, bus0.fail_reg, bus0.fail_data);
    end
  endtask

  task automatic test_fail_first();
    setGoodTable();
    chkVals[1] = 32'd11;
    chkVals[3] = 32'd0;
    startPulse0(); loadProg0(7); loadChk0(5); waitDone0(300);
    total++;
    if (bus0.pass !== 1'b0 || bus0.fail_reg !== 5'd2 || bus0.fail_data !== 32'd10) begin
      bad++; $display("[TB] FAIL fail_first got pass=%b reg=%0d data=%0d want 0,2,10",
                      bus0.pass, bus0.fail_reg, bus0.fail_data);
    end
  endtask

  task automatic test_chk_overflow();
    setGoodTable();
    chkRegs[5] = 5'd1; chkVals[5] = 32'd5;
    chkRegs[6] = 5'd2; chkVals[6] = 32'd10;
    chkRegs[7] = 5'd3; chkVals[7] = 32'd15;
    chkRegs[8] = 5'd1; chkVals[8] = 32'd99;
    startPulse0(); loadProg0(7); loadChk0(9); waitDone0(300);
    total++;
    if (bus0.overflow !== 1'b1 || bus0.pass !== 1'b0 || bus0.fail_reg !== 5'd0) begin
      bad++; $display("[TB] FAIL chk_overflow got ov=%b pass=%b fail_reg=%0d want 1,0,0",
                      bus0.overflow, bus0.pass, bus0.fail_reg);
    end
  endtask

  task automatic test_clear();
    int hw, expHw, expSpan;
    setGoodTable();
    hw = highWr0;
`ifdef SEQ_CLEAR_IMEM_EN
    expHw = 57; expSpan = 56;
`else
    expHw = 0;  expSpan = 0;
`endif
    startPulse0(); loadProg0(7); loadChk0(5); waitDone0(300);
    total++;
    if (highWr0 - hw !== expHw) begin bad++; $display("[TB] FAIL clear_count got=%0d want=%0d", highWr0 - hw, expHw); end
    total++;
    if (wr63Cyc - wr7Cyc !== expSpan) begin
      bad++; $display("[TB] FAIL clear_span got=%0d want=%0d", wr63Cyc - wr7Cyc, expSpan);
    end
`ifdef SEQ_CLEAR_IMEM_EN
    total++;
    if (imem0[8] !== 32'h0000_0013 || imem0[63] !== 32'h0000_0013) begin
      bad++; $display("[TB] FAIL clear_data got [8]=%h [63]=%h want 00000013", imem0[8], imem0[63]);
    end
`endif
    total++;
    if (bus0.pass !== 1'b1) begin bad++; $display("[TB] FAIL clear_pass got=%b want=1", bus0.pass); end
  endtask

  task automatic test_back_to_back();
    setGoodTable();
    startPulse0(); loadProg0(7); loadChk0(5);
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    waitDone0(300);
    total++;
    if (bus0.pass !== 1'b1 || bus0.run_cycles !== 16'd7) begin
      bad++; $display("[TB] FAIL start_busy got pass=%b rc=%0d want 1,7", bus0.pass, bus0.run_cycles);
    end
  endtask

  task automatic test_timeout();
    int g = 0;
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    bus1.prog_valid = 1'b1; bus1.prog_data = 32'h0000_0013; bus1.prog_last = 1'b1;
    @(negedge clk); bus1.prog_valid = 1'b0;
    bus1.chk_valid = 1'b1; bus1.chk_reg = 5'd7; bus1.chk_data = 32'd0; bus1.chk_last = 1'b1;
    while (bus1.chk_ready !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    @(negedge clk); bus1.chk_valid = 1'b0;
    g = 0;
    while (bus1.done !== 1'b1 && g < 600) begin @(negedge clk); g++; end
    total++;
    if (bus1.done !== 1'b1 || bus1.timeout !== 1'b1 || bus1.pass !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout got done=%b to=%b pass=%b want 1,1,0", bus1.done, bus1.timeout, bus1.pass);
    end
    total++;
    if (bus1.run_cycles !== 8'd255) begin bad++; $display("[TB] FAIL timeout_cycles got=%0d want=255", bus1.run_cycles); end
    total++;
    if (bus1.rf_raddr !== 5'd0 || bus1.fail_reg !== 5'd0 || bus1.cpu_rst !== 1'b1) begin
      bad++; $display("[TB] FAIL timeout_nocheck got ra=%0d fr=%0d cpu_rst=%b want 0,0,1",
                      bus1.rf_raddr, bus1.fail_reg, bus1.cpu_rst);
    end
  endtask

  task automatic test_prog_overflow();
    int g = 0;
    int w;
    w = writes2;
    @(negedge clk); bus2.start = 1'b1;
    @(negedge clk); bus2.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.prog_valid = 1'b1; bus2.prog_data = prog[i]; bus2.prog_last = (i == 5);
      @(negedge clk);
    end
    bus2.prog_valid = 1'b0; bus2.prog_last = 1'b0;
    bus2.chk_valid = 1'b1; bus2.chk_reg = 5'd1; bus2.chk_data = 32'd5; bus2.chk_last = 1'b1;
    while (bus2.chk_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    @(negedge clk); bus2.chk_valid = 1'b0;
    g = 0;
    while (bus2.done !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    total++;
    if (bus2.done !== 1'b1 || bus2.overflow !== 1'b1 || bus2.pass !== 1'b0 || bus2.fail_reg !== 5'd0) begin
      bad++; $display("[TB] FAIL prog_overflow got done=%b ov=%b pass=%b fr=%0d want 1,1,0,0",
                      bus2.done, bus2.overflow, bus2.pass, bus2.fail_reg);
    end
    total++;
    if (writes2 - w !== 4 || imem2[0] !== prog[0] || imem2[3] !== prog[3]) begin
      bad++; $display("[TB] FAIL prog_overflow_writes got n=%0d [0]=%h [3]=%h want 4,%h,%h",
                      writes2 - w, imem2[0], imem2[3], prog[0], prog[3]);
    end
  endtask

  task automatic test_reset_midrun();
    setGoodTable();
    startPulse0(); loadProg0(7); loadChk0(5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (bus0.busy !== 1'b0 || bus0.cpu_rst !== 1'b1 || bus0.done !== 1'b0 || bus0.pass !== 1'b0 ||
        bus0.timeout !== 1'b0 || bus0.overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL midrun_status got busy=%b cpu_rst=%b done=%b pass=%b to=%b ov=%b want 0,1,0,0,0,0",
                      bus0.busy, bus0.cpu_rst, bus0.done, bus0.pass, bus0.timeout, bus0.overflow);
    end
    total++;
    if (bus0.run_cycles !== 16'd0 || bus0.rf_raddr !== 5'd0 || bus0.prog_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL midrun_regs got rc=%0d ra=%0d pr=%b want 0,0,0",
                      bus0.run_cycles, bus0.rf_raddr, bus0.prog_ready);
    end
    startPulse0(); loadProg0(7); loadChk0(5); waitDone0(300);
    total++;
    if (bus0.pass !== 1'b1) begin bad++; $display("[TB] FAIL midrun_rerun got pass=%b want=1", bus0.pass); end
  endtask

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0030_2023;
    prog[4] = 32'h0000_2203;
    prog[5] = 32'h0012_02B3;
    prog[6] = 32'h0000_0073;
    prog[7] = 32'h0000_0013;
    for (int i = 0; i < 32; i++) rf0[i] = 32'd0;
    rf0[1] = 32'd5; rf0[2] = 32'd10; rf0[3] = 32'd15; rf0[4] = 32'd15; rf0[5] = 32'd20;
    rst = 1'b0;
    bus0.start = 1'b0; bus0.prog_valid = 1'b0; bus0.prog_data = '0; bus0.prog_last = 1'b0;
    bus0.chk_valid = 1'b0; bus0.chk_reg = '0; bus0.chk_data = '0; bus0.chk_last = 1'b0;
    bus1.start = 1'b0; bus1.prog_valid = 1'b0; bus1.prog_data = '0; bus1.prog_last = 1'b0;
    bus1.chk_valid = 1'b0; bus1.chk_reg = '0; bus1.chk_data = '0; bus1.chk_last = 1'b0;
    bus2.start = 1'b0; bus2.prog_valid = 1'b0; bus2.prog_data = '0; bus2.prog_last = 1'b0;
    bus2.chk_valid = 1'b0; bus2.chk_reg = '0; bus2.chk_data = '0; bus2.chk_last = 1'b0;
    test_reset();
    test_pass();
    test_fail_last();
    test_fail_first();
    test_chk_overflow();
    test_clear();
    test_back_to_back();
    test_timeout();
    test_prog_overflow();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Synthesizable self-checking harness that sits beside `cpu_top` and drives it through the whole test sequence. It streams a program into instruction memory and stores a table of expected register values, then releases the core from reset. It detects a halt instruction in fetch, lets the pipeline drain, and compares the register file against the table through a debug read port. It replaces fixed hierarchical preloads and fixed-delay checks with a parametrised, handshake-driven sequence that reports pass, fail or timeout.

## Interface
- `XLEN`, 32: data/instruction width.
- `IMEM_DEPTH`, 64: instruction words; address width `$clog2(IMEM_DEPTH)`.
- `NCHECK`, 8: expected-value table entries.
- `TIMEOUT_W`, 16: run-cycle counter width.
- `DRAIN`, 6: cycles run after halt detection.
- `HALT_INSN`, 32'h00000073: halt encoding (ecall).

- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a test from IDLE.
- `prog_valid` / `prog_ready`  in/out  1  program-stream handshake.
- `prog_data`  in  XLEN  instruction word.
- `prog_last`  in  1  marks the final program word.
- `chk_valid` / `chk_ready`  in/out  1  expected-value stream handshake.
- `chk_reg`  in  5  register index.
- `chk_data`  in  XLEN  expected value.
- `chk_last`  in  1  marks the final check entry.
- `imem_we`  out  1  IMEM write strobe.
- `imem_addr`  out  AW  IMEM write address.
- `imem_wdata`  out  XLEN  IMEM write data.
- `cpu_rst`  out  1  active-high reset to `cpu_top`.
- `if_insn`  in  XLEN  instruction currently in fetch.
- `rf_raddr`  out  5  debug register-file read address.
- `rf_rdata`  in  XLEN  debug read data (combinational).
- `busy`, `done`, `pass`, `timeout`, `overflow`  out  1  status.
- `fail_reg`  out  5  first mismatching register index.
- `fail_data`  out  XLEN  actual value of that register.
- `run_cycles`  out  TIMEOUT_W  cycles spent in RUN.

## Operation
- FSM states: IDLE, LOAD_PROG, CLEAR, LOAD_CHK, RUN, DRAIN, CHECK, DONE.
- IDLE:
  - `start` -> LOAD_PROG.
  - Clears the word pointer, entry count, status and `run_cycles`.
- LOAD_PROG:
  - `prog_ready`=1; each accepted word writes IMEM at the pointer, then the pointer increments.
  - Words beyond `IMEM_DEPTH` are still accepted but not written, and `overflow` is set.
  - Accepted `prog_last` -> CLEAR.
- CLEAR: covered under Configuration.
- LOAD_CHK:
  - `chk_ready`=1; each accepted entry is stored in the table.
  - Entries beyond `NCHECK` are dropped and set `overflow`.
  - Accepted `chk_last` -> RUN.
- RUN:
  - `cpu_rst`=0; `run_cycles` increments every cycle.
  - `if_insn==HALT_INSN` -> DRAIN.
  - `run_cycles` reaching all-ones -> DONE with `timeout`=1.
- DRAIN: `cpu_rst` stays 0 for exactly `DRAIN` cycles, then CHECK.
- CHECK:
  - `cpu_rst`=1 (core frozen; register file holds its contents).
  - One table entry per cycle: `rf_raddr`=entry reg, `rf_rdata` compared against entry data in the same cycle.
  - First mismatch -> DONE, latching `fail_reg` and `fail_data`; remaining entries are skipped.
  - All entries matching -> DONE.
- DONE:
  - `done`=1; `pass` = no mismatch, no timeout, no overflow.
  - Holds until `start`, which clears status and re-enters LOAD_PROG.
- `cpu_rst`=1 in every state except RUN and DRAIN.
- `busy`=1 in every state except IDLE and DONE.
- Zero check entries (`chk_last` on the first entry is legal and stores that entry; no entries at all are impossible) — a test always has at least one entry.
- `start` while busy is ignored.

## Timing
- Reset (`rst`=0 at an edge): next state IDLE.
  - `cpu_rst`=1.
  - `prog_ready`, `chk_ready`, `imem_we`, `busy`, `done`, `pass`, `timeout`, `overflow` = 0.
  - `fail_reg`, `fail_data`, `run_cycles`, `rf_raddr`, `imem_addr`, `imem_wdata` = 0.
- Reset is valid mid-operation in any state and abandons the test.
- IMEM write is registered: handshake at edge N -> `imem_we`/`imem_addr`/`imem_wdata` valid during cycle N+1.
- `prog_valid` and `prog_last` accepted together: the word is written, then the FSM moves to CLEAR.
- Halt seen in cycle N of RUN: DRAIN occupies cycles N+1..N+DRAIN; the first CHECK compare is in cycle N+DRAIN+1.
- Halt and timeout in the same cycle: halt wins.
- `done` rises in the cycle after the deciding compare or timeout.
- `run_cycles` saturates and freezes on leaving RUN.

## Configuration
- `SEQ_CLEAR_IMEM_EN` defined:
  - CLEAR writes 32'h00000013 (nop) to every address from the last program address + 1 up to `IMEM_DEPTH-1`, one per cycle, then moves to LOAD_CHK.
  - If the program filled memory, CLEAR lasts zero cycles.
- Undefined: CLEAR is skipped entirely and stale IMEM contents remain.

## Test plan
- Program: addi x1,5; addi x2,10; add x3; sw; lw x4; add x5; ecall. Checks x1..x5 = 5, 10, 15, 15, 20 -> `done`=1, `pass`=1, `fail_reg`=0.
- Same program, expected x5=21 -> `pass`=0, `fail_reg`=5, `fail_data`=20.
- Program with no ecall, `TIMEOUT_W`=8 -> `timeout`=1 and `run_cycles`=255; CHECK is never entered.
- `IMEM_DEPTH`=4, 6 program words -> `overflow`=1, only addresses 0..3 written, `pass`=0.
- `rst` pulled low for one edge during RUN -> next cycle IDLE, `cpu_rst`=1, all status 0; a new `start` then completes with `pass`=1.
- With `SEQ_CLEAR_IMEM_EN`, 3-word program, `IMEM_DEPTH`=8 -> IMEM[3..7]=0x00000013, written one per cycle; without the macro, no writes occur to addresses 3..7.
